// File: rtl/rom_scan_accum_if.sv
// rtl/rom_scan_accum_if.sv - control, status and ROM port bundle for rom_scan_accum
interface rom_scan_accum_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int SUM_W  = 40
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              busy;
    logic              done;
    logic [SUM_W-1:0]  sum;
    logic              overflow;

    modport master (
        output start, abort, base_addr, count, rom_data,
        input  rom_addr, busy, done, sum, overflow
    );

    modport slave (
        input  start, abort, base_addr, count, rom_data,
        output rom_addr, busy, done, sum, overflow
    );
endinterface

// File: rtl/rom_scan_accum.sv
// rtl/rom_scan_accum.sv - scans a ROM address range and accumulates the read data
module rom_scan_accum #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int SUM_W    = 40,
    parameter int READ_LAT = 1,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    rom_scan_accum_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Bits 1..READ_LAT-1 of the valid taps: all clear means the final sample is now.
    localparam logic [3:0] DRAIN_MASK = 4'((1 << READ_LAT) - 1) & 4'b1110;
    localparam logic [1:0] RL_IDX     = 2'(READ_LAT);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W:0]   remain;
    logic [3:1]        vpipe;
    logic [3:0]        vtap;
    logic [SUM_W-1:0]  sum_q;
    logic              ovf_q;
    logic [SUM_W:0]    sum_ext;
    logic              accept, kill, issue, sample, drain_last;

    assign accept     = (state == IDLE) && bus.start;
    assign kill       = bus.abort && ((state == RUN) || (state == DRAIN));
    assign issue      = (state == RUN);
    assign vtap       = {vpipe, issue};
    assign sample     = vtap[RL_IDX] && !kill;
    assign drain_last = (vtap & DRAIN_MASK) == 4'b0000;
    assign sum_ext    = {1'b0, sum_q} + (SUM_W+1)'(bus.rom_data);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start) state_nx = (bus.count == '0) ? DONE : RUN;
            RUN: begin
                if (kill)
                    state_nx = IDLE;
                else if (remain == (ADDR_W+1)'(1))
                    state_nx = (READ_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (kill)
                    state_nx = IDLE;
                else if (drain_last)
                    state_nx = DONE;
            end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rom_addr_q <= '0;
            remain     <= '0;
            vpipe      <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state <= state_nx;
            vpipe <= kill ? 3'b000 : {vpipe[2:1], issue};
            if (accept) begin
                rom_addr_q <= bus.base_addr;
                remain     <= bus.count;
                sum_q      <= '0;
                ovf_q      <= 1'b0;
            end else begin
                if (issue) begin
                    rom_addr_q <= rom_addr_q + ADDR_W'(1);
                    remain     <= remain - (ADDR_W+1)'(1);
                end
                if (sample) begin
                    if (sum_ext[SUM_W])
                        ovf_q <= 1'b1;
                    // Once clamped, the sum stays pinned for the remainder of the scan.
                    if ((SATURATE != 0) && (sum_ext[SUM_W] || ovf_q))
                        sum_q <= '1;
                    else
                        sum_q <= sum_ext[SUM_W-1:0];
                end
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = (state == RUN) || (state == DRAIN);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_rom_scan_accum.sv
// tb/tb_rom_scan_accum.sv - directed bench for rom_scan_accum across latency and saturation variants
module tb_rom_scan_accum;
    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] base;
    logic [8:0] count;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // a: READ_LAT=1, b: READ_LAT=0, c: READ_LAT=3, s0/s1: 8-bit wrap / saturate
    rom_scan_accum_if #(.ADDR_W(8), .DATA_W(32), .SUM_W(40)) ia ();
    rom_scan_accum_if #(.ADDR_W(8), .DATA_W(32), .SUM_W(40)) ib ();
    rom_scan_accum_if #(.ADDR_W(8), .DATA_W(32), .SUM_W(40)) ic ();
    rom_scan_accum_if #(.ADDR_W(8), .DATA_W(8),  .SUM_W(8))  is0 ();
    rom_scan_accum_if #(.ADDR_W(8), .DATA_W(8),  .SUM_W(8))  is1 ();

    rom_scan_accum #(.READ_LAT(1)) u_a (.clk(clk), .rst(rst), .bus(ia));
    rom_scan_accum #(.READ_LAT(0)) u_b (.clk(clk), .rst(rst), .bus(ib));
    rom_scan_accum #(.READ_LAT(3)) u_c (.clk(clk), .rst(rst), .bus(ic));
    rom_scan_accum #(.DATA_W(8), .SUM_W(8), .READ_LAT(1), .SATURATE(0)) u_s0 (.clk(clk), .rst(rst), .bus(is0));
    rom_scan_accum #(.DATA_W(8), .SUM_W(8), .READ_LAT(1), .SATURATE(1)) u_s1 (.clk(clk), .rst(rst), .bus(is1));

    assign ia.start  = start;  assign ia.abort  = abort;  assign ia.base_addr  = base;  assign ia.count  = count;
    assign ib.start  = start;  assign ib.abort  = abort;  assign ib.base_addr  = base;  assign ib.count  = count;
    assign ic.start  = start;  assign ic.abort  = abort;  assign ic.base_addr  = base;  assign ic.count  = count;
    assign is0.start = start;  assign is0.abort = abort;  assign is0.base_addr = base;  assign is0.count = count;
    assign is1.start = start;  assign is1.abort = abort;  assign is1.base_addr = base;  assign is1.count = count;

    // 200-entry image: 85, +1 on the first 92 entries, +/- pairs that cancel; total 17092.
    function automatic logic [31:0] rom_val(input logic [7:0] a);
        int i;
        int v;
        i = int'(a);
        if (i < 200)
            v = 85 + ((i < 92) ? 1 : 0) + (((i % 2) == 0) ? (i % 16) : -((i - 1) % 16));
        else
            v = (i * 3) % 256;
        return 32'(v);
    endfunction

    function automatic logic [7:0] rom8(input logic [7:0] a);
        if (a == 8'd0) return 8'd200;
        if (a == 8'd1) return 8'd100;
        return a;
    endfunction

    function automatic longint sum_range(input logic [7:0] b, input int n);
        longint s;
        logic [7:0] a;
        s = 0;
        for (int k = 0; k < n; k++) begin
            a = b + 8'(k);
            s += longint'(rom_val(a));
        end
        return s;
    endfunction

    logic [31:0] a_d1, c_d1, c_d2, c_d3;
    logic [7:0]  s0_d1, s1_d1;
    always @(posedge clk) begin
        a_d1  <= rom_val(ia.rom_addr);
        c_d1  <= rom_val(ic.rom_addr);
        c_d2  <= c_d1;
        c_d3  <= c_d2;
        s0_d1 <= rom8(is0.rom_addr);
        s1_d1 <= rom8(is1.rom_addr);
    end
    assign ia.rom_data  = a_d1;
    assign ib.rom_data  = rom_val(ib.rom_addr);
    assign ic.rom_data  = c_d3;
    assign is0.rom_data = s0_d1;
    assign is1.rom_data = s1_d1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int          done_cyc [5];
    int          n_done   [5];
    longint      sum_d    [5];
    logic        ovf_d    [5];
    logic        busy_seen;
    logic [7:0]  addr_log [$];

    task automatic note(input int idx, input logic d, input longint s, input logic o, input int cyc);
        if (d) begin
            n_done[idx]++;
            if (done_cyc[idx] < 0) begin
                done_cyc[idx] = cyc;
                sum_d[idx]    = s;
                ovf_d[idx]    = o;
            end
        end
    endtask

    // Pulses start in the current (IDLE) cycle, then samples cycles 1..ncyc at each negedge.
    task automatic scan(input logic [7:0] b, input logic [8:0] c, input int abort_at,
                        input int rst_at, input int restart_at, input int ncyc);
        for (int i = 0; i < 5; i++) begin
            done_cyc[i] = -1;
            n_done[i]   = 0;
            sum_d[i]    = 0;
            ovf_d[i]    = 1'b0;
        end
        busy_seen = 1'b0;
        addr_log.delete();
        base  = b;
        count = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            note(0, ia.done,  longint'(ia.sum),  ia.overflow,  cyc);
            note(1, ib.done,  longint'(ib.sum),  ib.overflow,  cyc);
            note(2, ic.done,  longint'(ic.sum),  ic.overflow,  cyc);
            note(3, is0.done, longint'(is0.sum), is0.overflow, cyc);
            note(4, is1.done, longint'(is1.sum), is1.overflow, cyc);
            busy_seen = busy_seen | ia.busy | ib.busy | ic.busy;
            if (cyc <= int'(c)) addr_log.push_back(ia.rom_addr);
            if (cyc == abort_at)     check("busy_before_abort", longint'(ia.busy), 1);
            if (cyc == abort_at + 1) check("busy_after_abort",  longint'(ia.busy), 0);
            if (cyc == rst_at + 1) begin
                check("rst_mid_addr", longint'(ia.rom_addr), 0);
                check("rst_mid_busy", longint'(ia.busy), 0);
                check("rst_mid_done", longint'(ia.done), 0);
                check("rst_mid_sum",  longint'(ia.sum), 0);
                check("rst_mid_ovf",  longint'(ia.overflow), 0);
            end
            abort = (cyc == abort_at);
            rst   = (cyc == rst_at);
            if (cyc == restart_at) begin
                start = 1'b1;
                base  = 8'd77;
                count = 9'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; base = 8'd0; count = 9'd0;
        repeat (2) @(negedge clk);
        check("rst_addr", longint'(ia.rom_addr), 0);
        check("rst_busy", longint'(ia.busy), 0);
        check("rst_done", longint'(ia.done), 0);
        check("rst_sum",  longint'(ia.sum), 0);
        check("rst_ovf",  longint'(ia.overflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full 200-entry scan on all three latencies
        scan(8'd0, 9'd200, -1, -1, -1, 260);
        check("lat1_done_cyc", done_cyc[0], 202);
        check("lat1_sum",      sum_d[0], 17092);
        check("lat1_ovf",      longint'(ovf_d[0]), 0);
        check("lat1_ndone",    n_done[0], 1);
        check("lat0_done_cyc", done_cyc[1], 201);
        check("lat0_sum",      sum_d[1], 17092);
        check("lat3_done_cyc", done_cyc[2], 204);
        check("lat3_sum",      sum_d[2], 17092);
        check("lat3_ndone",    n_done[2], 1);

        // Address wrap-around
        scan(8'd250, 9'd10, -1, -1, -1, 30);
        check("wrap_addr_len", addr_log.size(), 10);
        for (int k = 0; k < addr_log.size(); k++)
            check($sformatf("wrap_addr%0d", k), longint'(addr_log[k]), longint'((250 + k) % 256));
        check("wrap_sum",      sum_d[0], sum_range(8'd250, 10));
        check("wrap_done_cyc", done_cyc[0], 12);

        // Empty scan
        scan(8'd5, 9'd0, -1, -1, -1, 10);
        check("cnt0_done_cyc", done_cyc[0], 1);
        check("cnt0_sum",      sum_d[0], 0);
        check("cnt0_busy",     longint'(busy_seen), 0);
        check("cnt0_lat3_cyc", done_cyc[2], 1);

        // Carry out of an 8-bit accumulator
        scan(8'd0, 9'd2, -1, -1, -1, 10);
        check("wrap8_sum", sum_d[3], 44);
        check("wrap8_ovf", longint'(ovf_d[3]), 1);
        check("sat8_sum",  sum_d[4], 255);
        check("sat8_ovf",  longint'(ovf_d[4]), 1);

        // Abort during cycle 50: 48 / 46 elements have been accumulated
        scan(8'd0, 9'd200, 50, -1, -1, 260);
        check("abort_ndone",     n_done[0], 0);
        check("abort_sum_lat1",  longint'(ia.sum), sum_range(8'd0, 48));
        check("abort_sum_lat3",  longint'(ic.sum), sum_range(8'd0, 46));
        check("abort_ovf",       longint'(ia.overflow), 0);

        // Reset mid-scan
        scan(8'd0, 9'd200, -1, 30, -1, 60);
        check("rst_mid_ndone", n_done[0], 0);

        // Start while busy is ignored
        scan(8'd0, 9'd200, -1, -1, 100, 260);
        check("restart_done_cyc", done_cyc[0], 202);
        check("restart_sum",      sum_d[0], 17092);
        check("restart_ndone",    n_done[0], 1);

        // Back-to-back: second start in the IDLE cycle right after done
        scan(8'd0, 9'd5, -1, -1, -1, 7);
        check("b2b_first_done", done_cyc[0], 7);
        scan(8'd10, 9'd3, -1, -1, -1, 10);
        check("b2b_second_done", done_cyc[0], 5);
        check("b2b_second_sum",  sum_d[0], sum_range(8'd10, 3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
